// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW hazard tracker with stall/flush/forward control
// Optional feature macro: HAZARD_FORWARDING_EN (forward-select outputs, load-use-only stalls).
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16,
    localparam int FWD_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken_ex,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic [FWD_W-1:0]      fwd_sel_rs1,
    output logic [FWD_W-1:0]      fwd_sel_rs2,
    output logic [DEPTH-1:0]      inflight_valid,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      rw_q;
    logic [DEPTH-1:0]      mr_q;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    logic [CNT_W-1:0]      stall_cnt_q;

    logic [DEPTH-1:0]      match_rs1;
    logic [DEPTH-1:0]      match_rs2;
    logic                  hazard;
    logic                  entry0_valid_d;
    logic                  entry0_rw_d;

    always_comb begin
        match_rs1 = '0;
        match_rs2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_rs1[k] = id_rs1_used && (id_rs1 != '0) && valid_q[k] && rw_q[k] && (rd_q[k] == id_rs1);
            match_rs2[k] = id_rs2_used && (id_rs2 != '0) && valid_q[k] && rw_q[k] && (rd_q[k] == id_rs2);
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [FWD_W-1:0] sel_rs1;
    logic [FWD_W-1:0] sel_rs2;

    // Walk from oldest to youngest so the youngest producer wins.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs1[k]) sel_rs1 = FWD_W'(k + 1);
            if (match_rs2[k]) sel_rs2 = FWD_W'(k + 1);
        end
    end

    assign hazard      = (match_rs1[0] || match_rs2[0]) && mr_q[0];
    assign fwd_sel_rs1 = enable ? sel_rs1 : '0;
    assign fwd_sel_rs2 = enable ? sel_rs2 : '0;
`else
    assign hazard      = (|match_rs1) || (|match_rs2);
    assign fwd_sel_rs1 = '0;
    assign fwd_sel_rs2 = '0;
`endif

    // Only entry 0's load flag can ever matter; the rest ride along unread.
    logic unused_mr;
    assign unused_mr = ^mr_q;

    assign flush_if_id  = enable && branch_taken_ex;
    assign stall_if_id  = enable && id_valid && !branch_taken_ex && hazard;
    assign bubble_id_ex = stall_if_id || flush_if_id;

    assign entry0_valid_d = id_valid && !stall_if_id && !flush_if_id;
    assign entry0_rw_d    = id_reg_write && (id_rd != '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q     <= '0;
            rw_q        <= '0;
            mr_q        <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else if (enable) begin
            valid_q <= {valid_q[DEPTH-2:0], entry0_valid_d};
            rw_q    <= {rw_q[DEPTH-2:0], entry0_rw_d};
            mr_q    <= {mr_q[DEPTH-2:0], id_mem_read};
            rd_q[0] <= id_rd;
            for (int k = 1; k < DEPTH; k++) begin
                rd_q[k] <= rd_q[k-1];
            end
            if (stall_if_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign inflight_valid = valid_q;
    assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks against a queue-based hazard model
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int D  = 3;

    logic clk, arst_n, en, idv, u1, u2, rw, mr, br;
    logic [AW-1:0] rs1, rs2, rd;
    logic stall, bubble, flush, stall_b, bubble_b, flush_b;
    logic [1:0] fwd1, fwd2, fwd1_b, fwd2_b;
    logic [D-1:0] inflight, inflight_b;
    logic [15:0] cnt;
    logic [1:0] cnt_b;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .DEPTH(D), .CNT_W(16)) u_dut (
        .clk(clk), .arst_n(arst_n), .enable(en), .id_valid(idv),
        .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .id_rd(rd), .id_reg_write(rw), .id_mem_read(mr), .branch_taken_ex(br),
        .stall_if_id(stall), .bubble_id_ex(bubble), .flush_if_id(flush),
        .fwd_sel_rs1(fwd1), .fwd_sel_rs2(fwd2), .inflight_valid(inflight), .stall_cycles(cnt)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .DEPTH(D), .CNT_W(2)) u_dut_sat (
        .clk(clk), .arst_n(arst_n), .enable(en), .id_valid(idv),
        .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .id_rd(rd), .id_reg_write(rw), .id_mem_read(mr), .branch_taken_ex(br),
        .stall_if_id(stall_b), .bubble_id_ex(bubble_b), .flush_if_id(flush_b),
        .fwd_sel_rs1(fwd1_b), .fwd_sel_rs2(fwd2_b), .inflight_valid(inflight_b), .stall_cycles(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t        trk[$];
    int unsigned m_cnt, m_cnt2;
    int          errors, checks;

    function automatic int match_stage(bit used, bit [4:0] a);
        if (!used || a == 0) return 0;
        foreach (trk[k]) if (trk[k].v && trk[k].rw && trk[k].rd == a) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        int s1 = match_stage(u1, rs1);
        int s2 = match_stage(u2, rs2);
        bit haz;
`ifdef HAZARD_FORWARDING_EN
        haz = (s1 == 1 || s2 == 1) && trk[0].mr;
`else
        haz = (s1 != 0) || (s2 != 0);
`endif
        return en && idv && !br && haz;
    endfunction

    function automatic bit [1:0] exp_fwd(bit second);
`ifdef HAZARD_FORWARDING_EN
        if (!en) return 2'd0;
        return second ? 2'(match_stage(u2, rs2)) : 2'(match_stage(u1, rs1));
`else
        return 2'd0;
`endif
    endfunction

    function automatic bit [D-1:0] exp_inflight();
        bit [D-1:0] v = '0;
        foreach (trk[k]) v[k] = trk[k].v;
        return v;
    endfunction

    function automatic void model_reset();
        ent_t e = '{0, 0, 0, 0};
        trk.delete();
        for (int k = 0; k < D; k++) trk.push_back(e);
        m_cnt  = 0;
        m_cnt2 = 0;
    endfunction

    function automatic void model_update();
        ent_t e;
        bit   st;
        if (!en) return;
        st   = exp_stall();
        e.v  = idv && !st && !br;
        e.rd = rd;
        e.rw = rw && (rd != 0);
        e.mr = mr;
        trk.push_front(e);
        void'(trk.pop_back());
        if (st) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endfunction

    task automatic drive(bit v, bit [4:0] a1, bit ua1, bit [4:0] a2, bit ua2,
                         bit [4:0] d, bit w, bit m, bit b);
        idv = v; rs1 = a1; u1 = ua1; rs2 = a2; u2 = ua2; rd = d; rw = w; mr = m; br = b;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 1, 0);
        checks++; if (inflight !== 3'b000) begin errors++; $display("FAIL reset_inflight: got %b expected 000", inflight); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        arst_n = 1'b1;
        #1;
        checks++; if ({stall, bubble, flush} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {stall, bubble, flush}); end
        checks++; if ({fwd1, fwd2} !== 4'd0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", {fwd1, fwd2}); end
        idle();
    endtask

    task automatic test_raw_stall();
        drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
        tick();
        drive(1, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL raw_stall[%0d]: got %b expected %b", i, stall, exp_stall()); end
`ifndef HAZARD_FORWARDING_EN
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_lit[%0d]: got %b expected 1", i, stall); end
`endif
            tick();
            #1;
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall_end: got %b expected 0", stall); end
        checks++; if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL raw_stall_cnt: got %0d expected %0d", cnt, m_cnt); end
`ifndef HAZARD_FORWARDING_EN
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt3: got %0d expected 3", cnt); end
`endif
        tick();
        idle();
    endtask

    task automatic test_forward();
`ifdef HAZARD_FORWARDING_EN
        drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
        tick();
        drive(1, 0, 0, 5'd5, 1, 5'd0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_alu_stall: got %b expected 0", stall); end
        checks++; if (fwd2 !== 2'd1) begin errors++; $display("FAIL fwd_alu_sel1: got %0d expected 1", fwd2); end
        tick();
        #1;
        checks++; if (fwd2 !== 2'd2) begin errors++; $display("FAIL fwd_alu_sel2: got %0d expected 2", fwd2); end
        drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0);
        tick();
        drive(1, 5'd7, 1, 0, 0, 5'd0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stall); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b expected 0", stall); end
        checks++; if (fwd1 !== 2'd2) begin errors++; $display("FAIL load_use_fwd: got %0d expected 2", fwd1); end
        tick();
        idle();
`endif
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 0, 5'd9, 1, 1, 0);
        tick();
        drive(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 1);
        checks++; if ({flush, bubble, stall} !== 3'b110) begin errors++; $display("FAIL flush_ctrl: got %b expected 110", {flush, bubble, stall}); end
        tick();
        idle();
        checks++; if (inflight[0] !== 1'b0) begin errors++; $display("FAIL flush_entry0: got %b expected 0", inflight[0]); end
        checks++; if (inflight !== exp_inflight()) begin errors++; $display("FAIL flush_inflight: got %b expected %b", inflight, exp_inflight()); end
    endtask

    task automatic test_rd_zero();
        drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0);
        tick();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd0_stall: got %b expected 0", stall); end
        checks++; if (fwd1 !== 2'd0) begin errors++; $display("FAIL rd0_fwd: got %0d expected 0", fwd1); end
        tick();
        idle();
    endtask

    task automatic test_enable_freeze();
        bit [D-1:0] held;
        drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);
        tick();
        held = exp_inflight();
        en = 1'b0;
        drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 1);
        checks++; if ({stall, bubble, flush} !== 3'b000) begin errors++; $display("FAIL freeze_ctrl: got %b expected 000", {stall, bubble, flush}); end
        checks++; if ({fwd1, fwd2} !== 4'd0) begin errors++; $display("FAIL freeze_fwd: got %h expected 0", {fwd1, fwd2}); end
        repeat (3) tick();
        #1;
        checks++; if (inflight !== held) begin errors++; $display("FAIL freeze_inflight: got %b expected %b", inflight, held); end
        checks++; if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL freeze_cnt: got %0d expected %0d", cnt, m_cnt); end
        en = 1'b1;
        idle();
        checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL unfreeze_stall: got %b expected %b", stall, exp_stall()); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(7) != 0);
            drive($urandom_range(3) != 0, 5'($urandom_range(3)), $urandom_range(1) == 1,
                  5'($urandom_range(3)), $urandom_range(1) == 1, 5'($urandom_range(3)),
                  $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(7) == 0);
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, stall, exp_stall()); end
            checks++; if (flush !== (en && br)) begin errors++; $display("FAIL rnd_flush[%0d]: got %b expected %b", i, flush, en && br); end
            checks++; if (bubble !== (exp_stall() || (en && br))) begin errors++; $display("FAIL rnd_bubble[%0d]: got %b", i, bubble); end
            checks++; if (fwd1 !== exp_fwd(0)) begin errors++; $display("FAIL rnd_fwd1[%0d]: got %0d expected %0d", i, fwd1, exp_fwd(0)); end
            checks++; if (fwd2 !== exp_fwd(1)) begin errors++; $display("FAIL rnd_fwd2[%0d]: got %0d expected %0d", i, fwd2, exp_fwd(1)); end
            checks++; if (inflight !== exp_inflight()) begin errors++; $display("FAIL rnd_inflight[%0d]: got %b expected %b", i, inflight, exp_inflight()); end
            checks++; if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, cnt, m_cnt); end
            checks++; if (cnt_b !== 2'(m_cnt2)) begin errors++; $display("FAIL rnd_cnt_sat[%0d]: got %0d expected %0d", i, cnt_b, m_cnt2); end
            tick();
        end
        en = 1'b1;
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0);
            tick();
            drive(1, 5'd7, 1, 0, 0, 5'd0, 0, 0, 0);
            repeat (4) tick();
        end
        idle();
        checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", cnt_b); end
        checks++; if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected %0d", cnt, m_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 0, 0, 0, 0, 5'd4, 1, 1, 0);
        tick();
        drive(1, 5'd4, 1, 0, 0, 5'd0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1", stall); end
        #2;
        arst_n = 1'b0;
        #1;
        checks++; if (inflight !== 3'b000 || inflight_b !== 3'b000) begin errors++; $display("FAIL midreset_inflight: got %b/%b expected 000", inflight, inflight_b); end
        checks++; if (cnt !== 16'd0 || cnt_b !== 2'd0) begin errors++; $display("FAIL midreset_cnt: got %0d/%0d expected 0", cnt, cnt_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b expected 0", stall); end
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        idle();
        checks++; if (inflight !== 3'b000) begin errors++; $display("FAIL post_reset_inflight: got %b expected 000", inflight); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        arst_n = 1'b0;
        en     = 1'b1;
        idv = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; rd = 0; rw = 0; mr = 0; br = 0;
        model_reset();
        test_reset();
        test_raw_stall();
        test_forward();
        test_flush();
        test_rd_zero();
        test_enable_freeze();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked post-ID stages (0=EX, 1=MEM, 2=WB); legal range 2..6.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL define local FWD_W = $clog2(DEPTH+1), the forward-select width.
REQ-005 clk  input  1  main clock, rising edge.
REQ-006 arst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  run enable; 0 freezes all state.
REQ-008 id_valid  input  1  ID stage holds a real instruction.
REQ-009 id_rs1, id_rs2  input  REG_ADDR_W each  ID source register addresses.
REQ-010 id_rs1_used, id_rs2_used  input  1 each  the corresponding source is read.
REQ-011 id_rd  input  REG_ADDR_W  ID destination register.
REQ-012 id_reg_write, id_mem_read  input  1 each  ID writes rd / ID is a load.
REQ-013 branch_taken_ex  input  1  branch or jump resolved taken in EX this cycle.
REQ-014 stall_if_id  output  1  hold PC and IF/ID register.
REQ-015 bubble_id_ex  output  1  load a NOP into ID/EX.
REQ-016 flush_if_id  output  1  replace IF/ID contents with a NOP.
REQ-017 fwd_sel_rs1, fwd_sel_rs2  output  FWD_W each  0 = register file, k+1 = result of tracked stage k.
REQ-018 inflight_valid  output  DEPTH  per-stage tracker valid bits.
REQ-019 stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-020 SHALL keep a DEPTH-entry tracker; each entry holds {valid, rd, reg_write, mem_read}; reg_write SHALL be stored as 0 when rd==0.
REQ-021 On each enabled clock edge, entry k+1 SHALL take entry k, and the last entry SHALL be discarded.
REQ-022 Entry 0 SHALL take the ID fields when id_valid=1, flush_if_id=0 and stall_if_id=0; otherwise entry 0 SHALL be written empty (valid=0).
REQ-023 A source SHALL match stage k when it is used, its address is non-zero, and entry k has valid=1, reg_write=1 and rd equal to the source address.
REQ-024 Without the forwarding feature, stall_if_id SHALL be 1 when id_valid=1 and any source matches any stage.
REQ-025 flush_if_id SHALL equal branch_taken_ex.
REQ-026 bubble_id_ex SHALL equal stall_if_id OR flush_if_id.
REQ-027 Flush SHALL have priority: while branch_taken_ex=1, stall_if_id SHALL be 0 and the ID entry SHALL NOT be inserted.
REQ-028 All outputs other than inflight_valid and stall_cycles SHALL be combinational from the tracker state and the current inputs (0-cycle latency).
REQ-029 While enable=0, stall_if_id, bubble_id_ex and flush_if_id SHALL be 0 and fwd_sel SHALL be 0, and the tracker and counter SHALL hold their values.
REQ-030 stall_cycles SHALL increment by 1 on each enabled edge where stall_if_id=1, and SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-031 inflight_valid[k] SHALL equal the valid bit of entry k.

Reset
REQ-032 arst_n=0 SHALL asynchronously clear every tracker entry to empty and set stall_cycles to 0, including when asserted mid-stall or mid-flush.
REQ-033 Immediately after reset, stall_if_id, bubble_id_ex, flush_if_id and fwd_sel SHALL be 0 for any inputs with branch_taken_ex=0.

Configuration
REQ-034 Macro HAZARD_FORWARDING_EN SHALL enable forwarding.
REQ-035 With the macro defined, fwd_sel for each source SHALL be k+1 for the smallest matching k, or 0 when there is no match.
REQ-036 With the macro defined, stall_if_id SHALL be 1 only for load-use, i.e. when a source matches stage 0 and entry 0 has mem_read=1.
REQ-037 Without the macro, fwd_sel outputs SHALL be tied to 0, and stall behaviour SHALL follow REQ-024.

Verification
REQ-038 No macro: insert rd=5 write; next cycle ID rs1=5 used -> stall_if_id=1 for 3 consecutive cycles, then 0; stall_cycles=3.
REQ-039 Macro defined: ALU write rd=5; next cycle ID rs2=5 -> stall_if_id=0, fwd_sel_rs2=1; one cycle later -> fwd_sel_rs2=2.
REQ-040 Macro defined: load rd=7; next cycle ID rs1=7 -> exactly one stall cycle, then fwd_sel_rs1=2.
REQ-041 branch_taken_ex=1 together with a RAW hazard -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0; entry 0 empty on the next cycle.
REQ-042 Write to rd=0, then ID rs1=0 -> no stall, fwd_sel_rs1=0.
REQ-043 CNT_W=2 with a continuous stall -> stall_cycles reaches 3 and holds; arst_n pulse mid-stall -> counter 0 and inflight_valid all 0.
